serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 14 +
 rtl/fa_from_ha.sv | 28 ++
 rtl/halfAdder.sv | 12 +
 rtl/serial_adder.sv | 112 +++++++++++
 tb/tb_serial_adder.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and counter sizing.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/fa_from_ha.sv
// 1-bit full adder composed from two halfAdder cells and an OR on the carries.
module fa_from_ha (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s1, c1, c2;

    halfAdder u_ha1 (
        .A     (a),
        .B     (b),
        .Sum   (s1),
        .Carry (c1)
    );

    halfAdder u_ha2 (
        .A     (s1),
        .B     (cin),
        .Sum   (s),
        .Carry (c2)
    );

    assign cout = c1 | c2;

endmodule

// File: rtl/halfAdder.sv
// Existing 1-bit half adder cell.
module halfAdder (
    input  logic A,
    input  logic B,
    output logic Sum,
    output logic Carry
);

    assign Sum   = A ^ B;
    assign Carry = A & B;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first, one full-add per clock, result committed on entry to DONE.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sr, b_sr, s_sr, s_sr_next;
    logic             c_ff;
    logic [CW-1:0]    cnt;
    logic             fa_s, fa_cout;
    logic             last;

    fa_from_ha u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (c_ff),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // New sum bit enters at the MSB so the LSB-first stream lands in place after WIDTH steps.
    if (WIDTH == 1) begin : g_w1
        assign s_sr_next = fa_s;
    end else begin : g_wn
        assign s_sr_next = {fa_s, s_sr[WIDTH-1:1]};
    end

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = start ? SHIFT : IDLE;
            SHIFT:   state_next = last ? DONE : SHIFT;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            SHIFT: busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            c_ff  <= 1'b0;
            cnt   <= '0;
            Sum   <= '0;
            Carry <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr <= A;
                        b_sr <= B;
                        s_sr <= '0;
                        c_ff <= 1'b0;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    c_ff <= fa_cout;
                    s_sr <= s_sr_next;
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    cnt  <= cnt + CW'(1);
                    // Sum/Carry hold the previous result until the final step.
                    if (last) begin
                        Sum   <= s_sr_next;
                        Carry <= fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH 8, 4 and 1 against an arithmetic reference model.
module tb_serial_adder;

    typedef struct {
        logic [31:0] sum;
        logic        carry;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   vectors;
    int   miscompares;

    logic       start8, busy8, done8, carry8;
    logic [7:0] a8, b8, sum8;
    logic       start4, busy4, done4, carry4;
    logic [3:0] a4, b4, sum4;
    logic       start1, busy1, done1, carry1;
    logic       a1, b1, sum1;

    exp_t q8[$];
    exp_t q4[$];
    exp_t q1[$];
    exp_t e8, e4, e1;

    logic [7:0] prev_s8;
    logic       prev_c8;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .Sum(sum8), .Carry(carry8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4),
        .busy(busy4), .done(done4), .Sum(sum4), .Carry(carry4)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1),
        .busy(busy1), .done(done1), .Sum(sum1), .Carry(carry1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // {carry,sum} is simply the (w+1)-bit value of a+b.
    function automatic exp_t model(input int unsigned w, input logic [31:0] a,
                                   input logic [31:0] b, input int done_cyc);
        logic [63:0] full;
        exp_t        r;
        full    = 64'(a) + 64'(b);
        r.sum   = 32'(full & ((64'd1 << w) - 64'd1));
        r.carry = 1'(full >> w);
        r.cyc   = done_cyc;
        return r;
    endfunction

    // Monitors: pop on every done pulse and compare value and arrival cycle.
    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL done8_spurious: got done=1, expected done=0 at cycle %0d", cyc);
            end else begin
                e8 = q8.pop_front();
                check("sum8", 32'(sum8), e8.sum);
                check("carry8", 32'(carry8), 32'(e8.carry));
                check("done8_cycle", 32'(cyc), 32'(e8.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (done4) begin
            if (q4.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL done4_spurious: got done=1, expected done=0 at cycle %0d", cyc);
            end else begin
                e4 = q4.pop_front();
                check("sum4", 32'(sum4), e4.sum);
                check("carry4", 32'(carry4), 32'(e4.carry));
                check("done4_cycle", 32'(cyc), 32'(e4.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (done1) begin
            if (q1.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL done1_spurious: got done=1, expected done=0 at cycle %0d", cyc);
            end else begin
                e1 = q1.pop_front();
                check("sum1", 32'(sum1), e1.sum);
                check("carry1", 32'(carry1), 32'(e1.carry));
                check("done1_cycle", 32'(cyc), 32'(e1.cyc));
            end
        end
    end

    // One WIDTH=8 add with hold/busy checks across the whole operation.
    task automatic add8(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        @(negedge clk);
        start8 = 1'b1;
        a8     = a;
        b8     = b;
        e      = model(8, 32'(a), 32'(b), cyc + 1 + 8);
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        a8     = 8'($urandom);
        b8     = 8'($urandom);
        for (int k = 0; k < 8; k++) begin
            check("busy8_shift", 32'(busy8), 32'd1);
            check("done8_shift", 32'(done8), 32'd0);
            check("hold8", 32'({carry8, sum8}), 32'({prev_c8, prev_s8}));
            @(negedge clk);
        end
        @(negedge clk);
        check("busy8_idle", 32'(busy8), 32'd0);
        check("done8_idle", 32'(done8), 32'd0);
        prev_s8 = e.sum[7:0];
        prev_c8 = e.carry;
    endtask

    task automatic add4(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        start4 = 1'b1;
        a4     = a;
        b4     = b;
        q4.push_back(model(4, 32'(a), 32'(b), cyc + 1 + 4));
        @(negedge clk);
        start4 = 1'b0;
        a4     = 4'($urandom);
        b4     = 4'($urandom);
        repeat (4) @(negedge clk);
    endtask

    task automatic add1(input logic a, input logic b);
        @(negedge clk);
        start1 = 1'b1;
        a1     = a;
        b1     = b;
        q1.push_back(model(1, 32'(a), 32'(b), cyc + 1 + 1));
        @(negedge clk);
        start1 = 1'b0;
        a1     = 1'($urandom);
        b1     = 1'($urandom);
        repeat (1) @(negedge clk);
    endtask

    initial begin
        int base;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        start1 = 1'b0; a1 = '0; b1 = '0;
        prev_s8 = '0;
        prev_c8 = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_sum", 32'(sum8), 32'd0);
        check("rst_carry", 32'(carry8), 32'd0);
        rst_n = 1'b1;

        add8(8'h00, 8'h00);
        add8(8'hFF, 8'h01);
        add8(8'h80, 8'h80);
        add8(8'hA5, 8'h5A);
        add8(8'h01, 8'h02);

        // start held for 20 edges: accepts at P0 and P10 only.
        @(negedge clk);
        start8 = 1'b1;
        a8     = 8'h10;
        b8     = 8'h20;
        base   = cyc;
        q8.push_back(model(8, 32'h10, 32'h20, base + 1 + 8));
        q8.push_back(model(8, 32'h10, 32'h20, base + 11 + 8));
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if ((k % 10) < 8) begin
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end else begin
                a8 = 8'h10;
                b8 = 8'h20;
            end
        end
        start8  = 1'b0;
        prev_s8 = 8'h30;
        prev_c8 = 1'b0;

        for (int i = 0; i < 20; i++) add8(8'($urandom), 8'($urandom));

        // Asynchronous reset mid-operation: outputs clear at once, no done follows.
        @(negedge clk);
        start8 = 1'b1;
        a8     = 8'hFF;
        b8     = 8'hFF;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy8), 32'd0);
        check("arst_done", 32'(done8), 32'd0);
        check("arst_sum", 32'(sum8), 32'd0);
        check("arst_carry", 32'(carry8), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        prev_s8 = '0;
        prev_c8 = 1'b0;
        repeat (12) @(negedge clk);
        add8(8'h03, 8'h04);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) add4(4'(a), 4'(b));
        end

        add1(1'b0, 1'b0);
        add1(1'b0, 1'b1);
        add1(1'b1, 1'b0);
        add1(1'b1, 1'b1);

        repeat (12) @(negedge clk);
        check("drain8", 32'(q8.size()), 32'd0);
        check("drain4", 32'(q4.size()), 32'd0);
        check("drain1", 32'(q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
